alu_seq_ctrl: RTL and testbench

//  Multi-cycle sequencer in front of the 32-bit single-cycle ALU. It accepts one

---
 rtl/alu_seq_ctrl_if.sv | 40 ++++
 rtl/alu_seq_ctrl.sv | 162 ++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/alu_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// alu_seq_ctrl_if
// Groups every bus of the ALU sequencer into one bundle:
//   request channel : InValid/InReady handshake carrying InOp, InA, InB, InShamt
//   ALU drive bus   : AluA, AluB, AluOp out to the ALU; AluOut, AluZero back
//   result channel  : OutValid/OutReady handshake carrying OutRes, OutZero
// Modports:
//   slave  - the sequencer (alu_seq_ctrl)
//   master - the environment around it (requester, ALU and result consumer)
// ---------------------------------------------------------------------------
interface alu_seq_ctrl_if #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
);
  logic               InValid;
  logic               InReady;
  logic [3:0]         InOp;
  logic [DATA_W-1:0]  InA;
  logic [DATA_W-1:0]  InB;
  logic [SHAMT_W-1:0] InShamt;
  logic [DATA_W-1:0]  AluA;
  logic [DATA_W-1:0]  AluB;
  logic [3:0]         AluOp;
  logic [DATA_W-1:0]  AluOut;
  logic               AluZero;
  logic               OutValid;
  logic               OutReady;
  logic [DATA_W-1:0]  OutRes;
  logic               OutZero;

  modport slave (
    input  InValid, InOp, InA, InB, InShamt, AluOut, AluZero, OutReady,
    output InReady, AluA, AluB, AluOp, OutValid, OutRes, OutZero
  );

  modport master (
    output InValid, InOp, InA, InB, InShamt, AluOut, AluZero, OutReady,
    input  InReady, AluA, AluB, AluOp, OutValid, OutRes, OutZero
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// alu_seq_ctrl
// Multi-cycle sequencer in front of a single-cycle 32-bit ALU. Accepts one
// operation per request handshake, drives the ALU, and returns the result and
// its zero flag on the result handshake. Multi-bit shifts/rotates are built by
// iterating the ALU's 1-bit shift/rotate ops; rotr is issued as rotl by
// (width - amount).
// Ports:
//   Clk   - clock, rising edge
//   Reset - synchronous, active-high
//   bus   - alu_seq_ctrl_if.slave (request, ALU drive, result channels)
// All outputs are registered.
// ---------------------------------------------------------------------------
module alu_seq_ctrl #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic           Clk,
  input  logic           Reset,
  alu_seq_ctrl_if.slave  bus
);

  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b1001;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_ROTL = 4'b1100;
  localparam logic [3:0] OP_ROTR = 4'b1101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [DATA_W-1:0]  out_res_q;
  logic               out_zero_q;
  logic [DATA_W-1:0]  alu_a_q;   // doubles as the shift accumulator
  logic [DATA_W-1:0]  alu_b_q;
  logic [3:0]         alu_op_q;
  logic [SHAMT_W-1:0] count_q;

  // Decode of the incoming request: shift class, op to issue, iteration count
  logic               is_shift_d;
  logic [3:0]         shift_op_d;
  logic [SHAMT_W-1:0] count_d;

  // Request decode; rotr becomes rotl by (2**SHAMT_W - amount) mod 2**SHAMT_W
  always_comb begin
    is_shift_d = 1'b0;
    shift_op_d = bus.InOp;
    count_d    = bus.InShamt;
    case (bus.InOp)
      OP_SRA, OP_SLL, OP_SRL, OP_ROTL: begin
        is_shift_d = 1'b1;
      end
      OP_ROTR: begin
        is_shift_d = 1'b1;
        shift_op_d = OP_ROTL;
        count_d    = {SHAMT_W{1'b0}} - bus.InShamt;
      end
      default: begin
        is_shift_d = 1'b0;
      end
    endcase
  end

  // Sequencer FSM with registered handshake, ALU drive and result outputs
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_res_q   <= {DATA_W{1'b0}};
      out_zero_q  <= 1'b0;
      alu_a_q     <= {DATA_W{1'b0}};
      alu_b_q     <= {DATA_W{1'b0}};
      alu_op_q    <= 4'b0000;
      count_q     <= {SHAMT_W{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.InValid) begin
            in_ready_q <= 1'b0;
            if (!is_shift_d) begin
              // Undefined codes go to the ALU untouched as well
              alu_a_q  <= bus.InA;
              alu_b_q  <= bus.InB;
              alu_op_q <= bus.InOp;
              state_q  <= EXEC;
            end else if (count_d == {SHAMT_W{1'b0}}) begin
              // Zero-length shift: result is A itself, no ALU pass needed
              out_res_q   <= bus.InA;
              out_zero_q  <= (bus.InA == {DATA_W{1'b0}});
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              alu_a_q  <= bus.InA;
              alu_b_q  <= {DATA_W{1'b0}};
              alu_op_q <= shift_op_d;
              count_q  <= count_d;
              state_q  <= SHIFT;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        EXEC: begin
          out_res_q   <= bus.AluOut;
          out_zero_q  <= bus.AluZero;
          out_valid_q <= 1'b1;
          alu_a_q     <= {DATA_W{1'b0}};
          alu_b_q     <= {DATA_W{1'b0}};
          alu_op_q    <= 4'b0000;
          state_q     <= DONE;
        end
        SHIFT: begin
          if (count_q == {{(SHAMT_W-1){1'b0}}, 1'b1}) begin
            // Last iteration: take the ALU output straight into the result
            out_res_q   <= bus.AluOut;
            out_zero_q  <= bus.AluZero;
            out_valid_q <= 1'b1;
            alu_a_q     <= {DATA_W{1'b0}};
            alu_op_q    <= 4'b0000;
            count_q     <= {SHAMT_W{1'b0}};
            state_q     <= DONE;
          end else begin
            alu_a_q <= bus.AluOut;
            count_q <= count_q - {{(SHAMT_W-1){1'b0}}, 1'b1};
            state_q <= SHIFT;
          end
        end
        DONE: begin
          if (bus.OutReady) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end else begin
            state_q <= DONE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.InReady  = in_ready_q;
  assign bus.OutValid = out_valid_q;
  assign bus.OutRes   = out_res_q;
  assign bus.OutZero  = out_zero_q;
  assign bus.AluA     = alu_a_q;
  assign bus.AluB     = alu_b_q;
  assign bus.AluOp    = alu_op_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_seq_ctrl
// Directed bench for alu_seq_ctrl with a behavioural single-cycle ALU attached
// to the ALU drive bus. Expected results and latencies are hand-computed.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_seq_ctrl;

  logic Clk;
  logic Reset;
  int   tests_run;
  int   tests_failed;

  alu_seq_ctrl_if #(.DATA_W(32), .SHAMT_W(5)) bus ();

  alu_seq_ctrl #(.DATA_W(32), .SHAMT_W(5)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Behavioural single-cycle ALU; unknown codes yield 0
  always_comb begin
    case (bus.AluOp)
      4'b0000: bus.AluOut = bus.AluA + bus.AluB;
      4'b0001: bus.AluOut = bus.AluA - bus.AluB;
      4'b0010: bus.AluOut = bus.AluA & bus.AluB;
      4'b0011: bus.AluOut = bus.AluA | bus.AluB;
      4'b0100: bus.AluOut = ~bus.AluA;
      4'b1000: bus.AluOut = {bus.AluA[31], bus.AluA[31:1]};
      4'b1010: bus.AluOut = {1'b0, bus.AluA[31:1]};
      4'b1001: bus.AluOut = {bus.AluA[30:0], 1'b0};
      4'b1100: bus.AluOut = {bus.AluA[30:0], bus.AluA[31]};
      4'b1101: bus.AluOut = {bus.AluA[0], bus.AluA[31:1]};
      default: bus.AluOut = 32'h0000_0000;
    endcase
    bus.AluZero = (bus.AluOut == 32'h0000_0000);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one op, check latency, ALU op during execution, result and zero flag,
  // optionally stall the consumer for hold cycles, then complete the handshake.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh,
                        input logic [31:0] exp_res, input int exp_lat,
                        input logic [3:0] exp_aop, input int hold);
    int lat;
    @(negedge Clk);
    bus.InValid  = 1'b1;
    bus.InOp     = op;
    bus.InA      = a;
    bus.InB      = b;
    bus.InShamt  = sh;
    bus.OutReady = (hold > 0) ? 1'b0 : 1'b1;
    check_eq({tag, ".inready"}, {31'd0, bus.InReady}, 32'd1);
    @(posedge Clk);
    #1;
    bus.InValid = 1'b0;
    if (exp_lat > 0) begin
      check_eq({tag, ".aluop"}, {28'd0, bus.AluOp}, {28'd0, exp_aop});
    end
    lat = 0;
    while (!bus.OutValid && lat < 100) begin
      @(posedge Clk);
      #1;
      lat++;
    end
    check_eq({tag, ".latency"}, lat, exp_lat);
    check_eq({tag, ".res"}, bus.OutRes, exp_res);
    check_eq({tag, ".zero"}, {31'd0, bus.OutZero}, {31'd0, (exp_res == 32'd0)});
    for (int i = 0; i < hold; i++) begin
      @(negedge Clk);
      check_eq({tag, ".hold_res"}, bus.OutRes, exp_res);
      check_eq({tag, ".hold_zero"}, {31'd0, bus.OutZero}, {31'd0, (exp_res == 32'd0)});
      check_eq({tag, ".hold_valid"}, {31'd0, bus.OutValid}, 32'd1);
      check_eq({tag, ".hold_inready"}, {31'd0, bus.InReady}, 32'd0);
    end
    if (hold > 0) begin
      @(negedge Clk);
      bus.OutReady = 1'b1;
    end
    @(posedge Clk);
    #1;
    check_eq({tag, ".idle_valid"}, {31'd0, bus.OutValid}, 32'd0);
    check_eq({tag, ".idle_inready"}, {31'd0, bus.InReady}, 32'd1);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    Reset        = 1'b1;
    bus.InValid  = 1'b0;
    bus.InOp     = 4'b0000;
    bus.InA      = 32'd0;
    bus.InB      = 32'd0;
    bus.InShamt  = 5'd0;
    bus.OutReady = 1'b1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    check_eq("por.inready", {31'd0, bus.InReady}, 32'd1);
    check_eq("por.outvalid", {31'd0, bus.OutValid}, 32'd0);

    // Reset in the middle of a long shift
    @(negedge Clk);
    bus.InValid = 1'b1;
    bus.InOp    = 4'b1001;
    bus.InA     = 32'h0000_0001;
    bus.InShamt = 5'd31;
    @(negedge Clk);
    bus.InValid = 1'b0;
    repeat (3) @(negedge Clk);
    check_eq("midshift.aluop", {28'd0, bus.AluOp}, 32'd9);
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    check_eq("rst.inready", {31'd0, bus.InReady}, 32'd1);
    check_eq("rst.outvalid", {31'd0, bus.OutValid}, 32'd0);
    check_eq("rst.outres", bus.OutRes, 32'd0);
    check_eq("rst.outzero", {31'd0, bus.OutZero}, 32'd0);
    check_eq("rst.aluop", {28'd0, bus.AluOp}, 32'd0);
    check_eq("rst.alua", bus.AluA, 32'd0);

    run_op("add",     4'b0000, 32'd5,         32'd7,      5'd0,  32'd12,        1,  4'b0000, 0);
    run_op("sub",     4'b0001, 32'd9,         32'd9,      5'd0,  32'd0,         1,  4'b0001, 0);
    run_op("and",     4'b0010, 32'h0000_F0F0, 32'h0000_FF00, 5'd3, 32'h0000_F000, 1, 4'b0010, 0);
    run_op("not",     4'b0100, 32'hFFFF_FFFF, 32'd1,      5'd0,  32'd0,         1,  4'b0100, 0);
    run_op("undef",   4'b0111, 32'd3,         32'd4,      5'd0,  32'd0,         1,  4'b0111, 0);
    run_op("sll31",   4'b1001, 32'h0000_0001, 32'd0,      5'd31, 32'h8000_0000, 31, 4'b1001, 0);
    run_op("sll1",    4'b1001, 32'h8000_0000, 32'd0,      5'd1,  32'd0,         1,  4'b1001, 0);
    run_op("sra4",    4'b1000, 32'h8000_0000, 32'd0,      5'd4,  32'hF800_0000, 4,  4'b1000, 0);
    run_op("srl4",    4'b1010, 32'h8000_0000, 32'd0,      5'd4,  32'h0800_0000, 4,  4'b1010, 0);
    run_op("rotl1",   4'b1100, 32'h8000_0001, 32'd0,      5'd1,  32'h0000_0003, 1,  4'b1100, 0);
    run_op("rotr1",   4'b1101, 32'h0000_0001, 32'd0,      5'd1,  32'h8000_0000, 31, 4'b1100, 0);
    run_op("rotr0",   4'b1101, 32'h1234_5678, 32'd0,      5'd0,  32'h1234_5678, 0,  4'b0000, 0);
    run_op("hold",    4'b0000, 32'd3,         32'd4,      5'd0,  32'd7,         1,  4'b0000, 5);
    run_op("b2b",     4'b0011, 32'h0000_00F0, 32'h0000_000F, 5'd0, 32'h0000_00FF, 1, 4'b0011, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
